// File: rtl/fc_tile_scheduler.sv
// Address/enable sequencer for one fully connected layer: issues input/weight reads per tile of
// PO outputs, aligns MAC controls to RAM latency, drains the MAC and writes each tile back.
module fc_tile_scheduler #(
    parameter int unsigned INNEURON                = 800,
    parameter int unsigned OUTNEURON               = 500,
    parameter int unsigned PO                      = 10,
    parameter int unsigned RD_LAT                  = 2,
    parameter int unsigned MAC_LAT                 = 3,
    parameter int unsigned FC_INNEURON_ADDR_WIDTH  = 10,
    parameter int unsigned FC_WEIGHT_ADDR_WIDTH    = 15,
    parameter int unsigned FC_OUTNEURON_ADDR_WIDTH = 6
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic                               in_rden,
    output logic [FC_INNEURON_ADDR_WIDTH-1:0]  in_addr_a,
    output logic [FC_INNEURON_ADDR_WIDTH-1:0]  in_addr_b,
    output logic                               weight_rden,
    output logic [FC_WEIGHT_ADDR_WIDTH-1:0]    weight_addr,
    output logic                               mac_en,
    output logic                               accum_sload,
    output logic                               wb_valid,
    input  logic                               wb_ready,
    output logic [FC_OUTNEURON_ADDR_WIDTH-1:0] wb_addr,
    output logic [FC_OUTNEURON_ADDR_WIDTH-1:0] tile_idx
);

    localparam int unsigned T  = OUTNEURON / PO;
    localparam int unsigned H  = INNEURON / 2;
    localparam int unsigned D  = RD_LAT + MAC_LAT;
    localparam int unsigned KW = (H > 1) ? $clog2(H) : 1;
    localparam int unsigned DW = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned IW = FC_INNEURON_ADDR_WIDTH;
    localparam int unsigned WW = FC_WEIGHT_ADDR_WIDTH;
    localparam int unsigned TW = FC_OUTNEURON_ADDR_WIDTH;

    typedef enum logic [2:0] {StIdle, StIssue, StDrain, StWb, StFin} state_t;

    state_t            state_q;
    logic [KW-1:0]     k_q;
    logic [DW-1:0]     drain_q;
    logic              sload_src_q;
    logic [RD_LAT-1:0] rden_pipe_q;
    logic [RD_LAT-1:0] sload_pipe_q;

    // Weight addresses are tile-major and contiguous, so weight_addr simply keeps counting
    // across tiles; it holds its value through DRAIN/WB and resumes on the next ISSUE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            k_q         <= '0;
            drain_q     <= '0;
            sload_src_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            in_rden     <= 1'b0;
            weight_rden <= 1'b0;
            in_addr_a   <= '0;
            in_addr_b   <= '0;
            weight_addr <= '0;
            wb_valid    <= 1'b0;
            wb_addr     <= '0;
            tile_idx    <= '0;
        end else begin
            sload_src_q <= 1'b0;
            done        <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StIssue;
                        busy        <= 1'b1;
                        in_rden     <= 1'b1;
                        weight_rden <= 1'b1;
                        in_addr_a   <= '0;
                        in_addr_b   <= IW'(1);
                        weight_addr <= '0;
                        tile_idx    <= '0;
                        k_q         <= '0;
                        sload_src_q <= 1'b1;
                    end
                end
                StIssue: begin
                    if (k_q == KW'(H - 1)) begin
                        state_q     <= StDrain;
                        in_rden     <= 1'b0;
                        weight_rden <= 1'b0;
                        k_q         <= '0;
                        drain_q     <= '0;
                    end else begin
                        k_q         <= k_q + KW'(1);
                        in_addr_a   <= in_addr_a + IW'(2);
                        in_addr_b   <= in_addr_b + IW'(2);
                        weight_addr <= weight_addr + WW'(1);
                    end
                end
                StDrain: begin
                    if (drain_q == DW'(D - 1)) begin
                        state_q  <= StWb;
                        wb_valid <= 1'b1;
                        wb_addr  <= tile_idx;
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                StWb: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        wb_addr  <= '0;
                        if (tile_idx == TW'(T - 1)) begin
                            state_q     <= StFin;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            tile_idx    <= '0;
                            in_addr_a   <= '0;
                            in_addr_b   <= '0;
                            weight_addr <= '0;
                        end else begin
                            state_q     <= StIssue;
                            tile_idx    <= tile_idx + TW'(1);
                            in_rden     <= 1'b1;
                            weight_rden <= 1'b1;
                            in_addr_a   <= '0;
                            in_addr_b   <= IW'(1);
                            weight_addr <= weight_addr + WW'(1);
                            sload_src_q <= 1'b1;
                        end
                    end
                end
                StFin: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read-latency alignment; runs in every state so the tail of a tile still reaches the MAC.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rden_pipe_q  <= '0;
            sload_pipe_q <= '0;
        end else begin
            rden_pipe_q[0]  <= in_rden;
            sload_pipe_q[0] <= sload_src_q;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                rden_pipe_q[i]  <= rden_pipe_q[i-1];
                sload_pipe_q[i] <= sload_pipe_q[i-1];
            end
        end
    end

    assign mac_en      = rden_pipe_q[RD_LAT-1];
    assign accum_sload = sload_pipe_q[RD_LAT-1];

endmodule

// File: tb/tb_fc_tile_scheduler.sv
// Scoreboard bench for fc_tile_scheduler: a nominal (8/4/2) and a minimal (2/2/2) instance share
// directed plus random start/reset/wb_ready stimulus; a timeline model predicts every cycle.
module tb_fc_tile_scheduler;

    localparam int RD = 2;
    localparam int DL = RD + 3;
    localparam int N  = 1500;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic wb_ready = 1'b1;

    always #5 clock = ~clock;

    logic       busy_n, done_n, in_rden_n, weight_rden_n, mac_en_n, accum_sload_n, wb_valid_n;
    logic [9:0] in_addr_a_n, in_addr_b_n;
    logic [14:0] weight_addr_n;
    logic [5:0] wb_addr_n, tile_idx_n;
    logic       busy_b, done_b, in_rden_b, weight_rden_b, mac_en_b, accum_sload_b, wb_valid_b;
    logic [9:0] in_addr_a_b, in_addr_b_b;
    logic [14:0] weight_addr_b;
    logic [5:0] wb_addr_b, tile_idx_b;

    fc_tile_scheduler #(
        .INNEURON(8), .OUTNEURON(4), .PO(2), .RD_LAT(RD), .MAC_LAT(3),
        .FC_INNEURON_ADDR_WIDTH(10), .FC_WEIGHT_ADDR_WIDTH(15), .FC_OUTNEURON_ADDR_WIDTH(6)
    ) u_nom (
        .clock(clock), .reset(reset), .start(start), .busy(busy_n), .done(done_n),
        .in_rden(in_rden_n), .in_addr_a(in_addr_a_n), .in_addr_b(in_addr_b_n),
        .weight_rden(weight_rden_n), .weight_addr(weight_addr_n), .mac_en(mac_en_n),
        .accum_sload(accum_sload_n), .wb_valid(wb_valid_n), .wb_ready(wb_ready),
        .wb_addr(wb_addr_n), .tile_idx(tile_idx_n)
    );

    fc_tile_scheduler #(
        .INNEURON(2), .OUTNEURON(2), .PO(2), .RD_LAT(RD), .MAC_LAT(3),
        .FC_INNEURON_ADDR_WIDTH(10), .FC_WEIGHT_ADDR_WIDTH(15), .FC_OUTNEURON_ADDR_WIDTH(6)
    ) u_bnd (
        .clock(clock), .reset(reset), .start(start), .busy(busy_b), .done(done_b),
        .in_rden(in_rden_b), .in_addr_a(in_addr_a_b), .in_addr_b(in_addr_b_b),
        .weight_rden(weight_rden_b), .weight_addr(weight_addr_b), .mac_en(mac_en_b),
        .accum_sload(accum_sload_b), .wb_valid(wb_valid_b), .wb_ready(wb_ready),
        .wb_addr(wb_addr_b), .tile_idx(tile_idx_b)
    );

    typedef struct {
        int rden, a, b, w, mac, sload, wbv, wba, busy, done, tile, idle;
    } exp_t;

    exp_t ex[2][N];
    exp_t q0[$];
    exp_t q1[$];
    bit   st[N];
    bit   rs[N];
    bit   rd[N];
    int   n_vec = 0;
    int   n_bad = 0;

    // Layer timeline from the start cycle: H issue cycles per tile, WB opens H+D cycles after the
    // tile's first issue, and the next tile starts the cycle after acceptance.
    task automatic build(input int u, input int h, input int t);
        int ign, s, r, wv, acc, f;
        for (int c = 0; c < N; c++) begin
            ex[u][c] = '{default: 0};
            ex[u][c].idle = 1;
        end
        ign = -1;
        for (int c = 0; c < N; c++) begin
            if (st[c] && !rs[c] && c > ign) begin
                s = c + 1;
                r = N;
                for (int x = s; x < N; x++) begin
                    if (rs[x]) begin
                        r = x;
                        break;
                    end
                end
                for (int tt = 0; tt < t && s < r; tt++) begin
                    for (int k = 0; k < h; k++) begin
                        if (s + k < r) begin
                            ex[u][s+k].rden = 1;
                            ex[u][s+k].a    = 2 * k;
                            ex[u][s+k].b    = 2 * k + 1;
                            ex[u][s+k].w    = tt * h + k;
                        end
                        if (s + k + RD < r) begin
                            ex[u][s+k+RD].mac   = 1;
                            ex[u][s+k+RD].sload = (k == 0) ? 1 : 0;
                        end
                    end
                    wv  = s + h + DL;
                    acc = wv;
                    while (acc < r && !rd[acc]) acc++;
                    for (int cy = s; cy <= acc && cy < r; cy++) begin
                        ex[u][cy].busy = 1;
                        ex[u][cy].tile = tt;
                        ex[u][cy].idle = 0;
                    end
                    for (int cy = wv; cy <= acc && cy < r; cy++) begin
                        ex[u][cy].wbv = 1;
                        ex[u][cy].wba = tt;
                    end
                    s = acc + 1;
                end
                f = s;
                if (f < r) begin
                    ex[u][f].done = 1;
                    ex[u][f].idle = 0;
                    ign = f;
                end else begin
                    ign = r;
                end
            end
        end
        for (int c = 0; c < N; c++) begin
            if (rs[c] || (c > 0 && rs[c-1])) begin
                ex[u][c] = '{default: 0};
                ex[u][c].idle = 1;
            end
        end
    endtask

    task automatic chk(input string nm, input int u, input int c, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, u, c, act, req);
        end
    endtask

    task automatic check_unit(input int u, input int c, input exp_t e,
                              input logic bsy, input logic dn, input logic rdn, input logic wrdn,
                              input logic mac, input logic sld, input logic wbv,
                              input int a, input int b, input int w, input int wba,
                              input int tile);
        chk("in_rden", u, c, int'(rdn), e.rden);
        chk("weight_rden", u, c, int'(wrdn), e.rden);
        chk("mac_en", u, c, int'(mac), e.mac);
        chk("accum_sload", u, c, int'(sld), e.sload);
        chk("wb_valid", u, c, int'(wbv), e.wbv);
        chk("busy", u, c, int'(bsy), e.busy);
        chk("done", u, c, int'(dn), e.done);
        if (e.rden != 0 || e.idle != 0) begin
            chk("in_addr_a", u, c, a, e.a);
            chk("in_addr_b", u, c, b, e.b);
            chk("weight_addr", u, c, w, e.w);
        end
        if (e.wbv != 0 || e.idle != 0) chk("wb_addr", u, c, wba, e.wba);
        if (e.busy != 0 || e.idle != 0) chk("tile_idx", u, c, tile, e.tile);
    endtask

    // Stimulus plan, model, then drive; all inputs change 1 time unit after the rising edge.
    initial begin
        for (int c = 0; c < N; c++) begin
            st[c] = 1'b0;
            rs[c] = 1'b0;
            rd[c] = 1'b1;
        end
        rs[0] = 1'b1;
        rs[1] = 1'b1;
        st[5] = 1'b1;                                   // nominal layer
        st[40] = 1'b1;                                  // backpressure during tile 0 WB
        for (int c = 50; c <= 53; c++) rd[c] = 1'b0;
        st[80] = 1'b1;                                  // start pulses while busy and in FIN
        st[85] = 1'b1;
        st[101] = 1'b1;
        st[130] = 1'b1;                                 // reset mid-tile, then restart
        rs[136] = 1'b1;
        st[138] = 1'b1;
        st[180] = 1'b1;                                 // back-to-back layers
        st[202] = 1'b1;
        for (int c = 250; c < N - 30; c++) begin
            rd[c] = ($urandom_range(3, 0) != 0);
            st[c] = ($urandom_range(29, 0) == 0);
            rs[c] = ($urandom_range(499, 0) == 0);
        end
        build(0, 4, 2);
        build(1, 1, 1);
        for (int c = 0; c < N; c++) begin
            q0.push_back(ex[0][c]);
            q1.push_back(ex[1][c]);
        end
        for (int c = 0; c < N; c++) begin
            @(posedge clock);
            #1;
            reset    = rs[c];
            start    = st[c];
            wb_ready = rd[c];
        end
    end

    initial begin
        exp_t e;
        for (int c = 0; c < N; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (q0.size() == 0 || q1.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL scoreboard cycle %0d: got empty queue expected entry", c);
            end else begin
                e = q0.pop_front();
                check_unit(0, c, e, busy_n, done_n, in_rden_n, weight_rden_n, mac_en_n,
                           accum_sload_n, wb_valid_n, int'(in_addr_a_n), int'(in_addr_b_n),
                           int'(weight_addr_n), int'(wb_addr_n), int'(tile_idx_n));
                e = q1.pop_front();
                check_unit(1, c, e, busy_b, done_b, in_rden_b, weight_rden_b, mac_en_b,
                           accum_sload_b, wb_valid_b, int'(in_addr_a_b), int'(in_addr_b_b),
                           int'(weight_addr_b), int'(wb_addr_b), int'(tile_idx_b));
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fc_tile_scheduler.md
# fc_tile_scheduler

Sequencer for one fully connected layer on the dual-port FC MAC datapath. It walks the output neurons in tiles of PO. For each tile it streams INNEURON/2 input-neuron address pairs and matching weight addresses, and aligns `mac_en`/`accum_sload` to the memory read latency. It then drains the MAC pipeline and hands each finished tile to the output-neuron buffer through a valid/ready writeback. It sits between the layer-level start/done control and the in-neuron RAM, weight RAM, MAC array and out-neuron RAM.

## Interface
Parameters:
- INNEURON, 800, input neurons per output; must be even and ≥ 2.
- OUTNEURON, 500, output neurons; must be a multiple of PO.
- PO, 10, output neurons computed in parallel per tile.
- RD_LAT, 2, cycles from rden/address to valid RAM q.
- MAC_LAT, 3, cycles from the last mac_en to a stable accumulator result.
- FC_INNEURON_ADDR_WIDTH, 10, width of in-neuron address.
- FC_WEIGHT_ADDR_WIDTH, 15, width of weight address; must hold OUTNEURON/PO*INNEURON/2-1.
- FC_OUTNEURON_ADDR_WIDTH, 6, width of tile/writeback address; must hold OUTNEURON/PO-1.

Ports:
- clock  in  1  clock; all logic on posedge.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  layer start pulse; sampled only in IDLE.
- busy  out  1  high while a layer is in progress.
- done  out  1  one-cycle pulse when the layer completes.
- in_rden  out  1  read enable for both in-neuron ports.
- in_addr_a  out  FC_INNEURON_ADDR_WIDTH  port A address = 2k.
- in_addr_b  out  FC_INNEURON_ADDR_WIDTH  port B address = 2k+1.
- weight_rden  out  1  weight RAM read enable; equals in_rden.
- weight_addr  out  FC_WEIGHT_ADDR_WIDTH  = tile*(INNEURON/2)+k.
- mac_en  out  1  MAC accumulate enable; equals in_rden delayed RD_LAT.
- accum_sload  out  1  load (not add) on the first pair of a tile; aligned with mac_en.
- wb_valid  out  1  finished tile is available.
- wb_ready  in  1  out-neuron buffer accepts the tile.
- wb_addr  out  FC_OUTNEURON_ADDR_WIDTH  tile index being written back.
- tile_idx  out  FC_OUTNEURON_ADDR_WIDTH  current tile.

## Operation
- Let T = OUTNEURON/PO, H = INNEURON/2 and D = RD_LAT+MAC_LAT.
- States are IDLE, ISSUE, DRAIN, WB and FIN.
- IDLE: all outputs are low or zero. When start=1, go to ISSUE, with tile=0 and k=0.
- ISSUE: in_rden=weight_rden=1 and addresses are driven from k. k increments each cycle. At k=H-1, go to DRAIN, with k cleared and the drain counter cleared.
- DRAIN: no reads. The drain counter counts D cycles, then goes to WB.
- WB: wb_valid=1 and wb_addr=tile. wb_valid, wb_addr and tile_idx are held stable until wb_ready=1.
- On acceptance in WB: if tile=T-1, go to FIN. Otherwise tile increments and the state goes to ISSUE.
- FIN: done=1 for exactly one cycle, busy=0, then go to IDLE.
- accum_sload source flag is high in the ISSUE cycle with k=0. Both this flag and in_rden pass through an RD_LAT-deep shift register to produce accum_sload and mac_en.
- The pipeline stays running in all states, so mac_en falls RD_LAT cycles after the last ISSUE cycle.
- start outside IDLE is ignored. start in the FIN cycle is ignored.
- Counters never wrap past their terminal values. Address arithmetic is unsigned and sized to its port width.
- Reset, asynchronous and at any time including mid-tile:
  - state goes to IDLE;
  - all counters and delay stages are cleared;
  - all outputs go to 0.
- The MAC accumulator content is not touched by this block.

## Timing
- Define cycle 0 as the edge that samples start=1. ISSUE runs in cycles 1..H and busy=1 from cycle 1.
- Tile 0 timing:
  - mac_en is high in cycles 1+RD_LAT..H+RD_LAT;
  - accum_sload is high in cycle 1+RD_LAT only;
  - DRAIN runs in cycles H+1..H+D;
  - WB starts in cycle H+D+1.
- With wb_ready held high the tile period is P = H+D+1, and done pulses in cycle T*P+1 with busy=0 in that cycle.
- Each cycle of wb_ready=0 in WB adds exactly one cycle. No reads are issued during the wait.
- Outputs are registered, except accum_sload and mac_en, which are the registered outputs of the delay chain.

## Test plan
- Nominal run, with INNEURON=8, OUTNEURON=4, PO=2, RD_LAT=2, MAC_LAT=3 and wb_ready tied to 1:
  - ISSUE runs in cycles 1-4 with in_addr_a=0,2,4,6, in_addr_b=1,3,5,7 and weight_addr=0..3;
  - mac_en is high in cycles 3-6 and accum_sload in cycle 3;
  - wb_valid is high in cycle 10 with wb_addr=0;
  - tile 1 has weight_addr=4..7 in cycles 11-14 and wb_addr=1 in cycle 20;
  - done pulses in cycle 21.
- Backpressure, same config with wb_ready=0 for cycles 10-13: wb_valid and wb_addr=0 are held, no in_rden is issued, tile 1 issue starts in cycle 15, and done is delayed by 4 cycles, to cycle 25.
- Start while busy, with start pulsed in cycle 5 and in the FIN cycle: no effect on addresses and a single done.
- Reset mid-operation, with reset asserted in cycle 6: all outputs are 0 immediately. start in cycle 8 then reproduces the nominal sequence offset by 8.
- Boundary, with INNEURON=2 and OUTNEURON=PO: one ISSUE cycle with accum_sload and mac_en in the same cycle, and done in cycle H+D+2=8.
- Back-to-back layers: start is asserted the cycle after done, and the second layer repeats identical addresses from tile 0.
